// File: rtl/spi_pkg.sv
// Shared types and mode constants for the SPI master.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } spi_master_state_t;

    localparam int unsigned SPI_CPOL = 0;
    localparam int unsigned SPI_CPHA = 0;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator: tick fires on every CLK_DIV-th enabled cycle.
module spi_clk_div #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    always_comb begin
        tick  = en && (cnt_q == DIV_W'(CLK_DIV - 1));
        cnt_d = cnt_q;
        if (clr || tick) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master: one word per valid/ready handshake, full duplex, MSB first.
module spi_master
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned CS_GAP  = 2
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    input  logic              MISO,
    output logic              SCK,
    output logic              MOSI,
    output logic              SS,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              done,
    output logic              busy_o
);

    localparam int unsigned BIT_W = $clog2(DATA_W);
    localparam int unsigned GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

    if (DATA_W < 2) begin : g_chk_data_w
        $error("spi_master: DATA_W must be >= 2");
    end
    if (CLK_DIV < 2) begin : g_chk_clk_div
        $error("spi_master: CLK_DIV must be >= 2");
    end
    if (CS_GAP < 1) begin : g_chk_cs_gap
        $error("spi_master: CS_GAP must be >= 1");
    end
    if (SPI_CPOL != 0 || SPI_CPHA != 0) begin : g_chk_mode
        $error("spi_master: only mode 0 is implemented");
    end

    spi_master_state_t state_q;
    logic [DATA_W-1:0] tx_sh_q;
    logic [DATA_W-1:0] rx_sh_q;
    logic [DATA_W-1:0] rx_data_q;
    logic [BIT_W-1:0]  bit_cnt_q;
    logic [GAP_W-1:0]  gap_cnt_q;
    logic              hold_half_q;
    logic              sck_q;
    logic              ss_q;
    logic              mosi_q;
    logic              ready_q;
    logic              busy_q;
    logic              done_q;

    logic div_en;
    logic div_tick;

    assign div_en = state_q inside {SETUP, SHIFT, HOLD};

    spi_clk_div #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_div (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .en     (div_en),
        .clr    (!div_en),
        .tick   (div_tick)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            tx_sh_q     <= '0;
            rx_sh_q     <= '0;
            rx_data_q   <= '0;
            bit_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            hold_half_q <= 1'b0;
            sck_q       <= 1'b0;
            ss_q        <= 1'b1;
            mosi_q      <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (tx_valid_i && ready_q) begin
                        tx_sh_q   <= tx_data_i;
                        mosi_q    <= tx_data_i[DATA_W-1];
                        ss_q      <= 1'b0;
                        ready_q   <= 1'b0;
                        busy_q    <= 1'b1;
                        bit_cnt_q <= '0;
                        state_q   <= SETUP;
                    end
                end
                SETUP: begin
                    if (div_tick) begin
                        sck_q   <= 1'b1;
                        rx_sh_q <= {rx_sh_q[DATA_W-2:0], MISO};
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (div_tick) begin
                        sck_q <= !sck_q;
                        if (!sck_q) begin
                            rx_sh_q <= {rx_sh_q[DATA_W-2:0], MISO};
                        end else if (bit_cnt_q == BIT_W'(DATA_W - 1)) begin
                            hold_half_q <= 1'b0;
                            state_q     <= HOLD;
                        end else begin
                            tx_sh_q   <= tx_sh_q << 1;
                            mosi_q    <= tx_sh_q[DATA_W-2];
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
                // The last bit keeps its full low half-period before the CLK_DIV hold.
                HOLD: begin
                    if (div_tick) begin
                        if (!hold_half_q) begin
                            hold_half_q <= 1'b1;
                        end else begin
                            ss_q      <= 1'b1;
                            done_q    <= 1'b1;
                            rx_data_q <= rx_sh_q;
                            mosi_q    <= 1'b0;
                            gap_cnt_q <= '0;
                            state_q   <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt_q == GAP_W'(CS_GAP - 1)) begin
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx_ready_o = ready_q;
    assign SCK        = sck_q;
    assign MOSI       = mosi_q;
    assign SS         = ss_q;
    assign rx_data_o  = rx_data_q;
    assign done       = done_q;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: vector table, random frames, reset and back-to-back sequences.
module tb_spi_master;

    localparam int FRAME  = 72;
    localparam int FRAME2 = 36;

    logic       clk = 1'b0;
    logic       reset_i = 1'b1;
    logic [7:0] tx_data_i = 8'h00;
    logic       tx_valid_i = 1'b0;
    logic       tx_ready_o;
    logic       MISO = 1'b0;
    logic       SCK;
    logic       MOSI;
    logic       SS;
    logic [7:0] rx_data_o;
    logic       done;
    logic       busy_o;

    logic [7:0] data2 = 8'h00;
    logic       valid2 = 1'b0;
    logic       ready2;
    logic       miso2 = 1'b0;
    logic       sck2;
    logic       mosi2;
    logic       ss2;
    logic [7:0] rx2;
    logic       done2;
    logic       busy2;

    int checks = 0;
    int errors = 0;
    int mosi_viol = 0;
    logic mosi_prev = 1'b0;
    logic [7:0] rcv_sh = 8'h00;
    int rcv_n = 0;

    typedef struct {
        logic [7:0] data;
        logic [7:0] miso;
        bit         loop;
        logic [7:0] exp_rx;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    spi_master #(.DATA_W(8), .CLK_DIV(4), .CS_GAP(2)) u_dut (
        .clk_i(clk), .reset_i(reset_i), .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i),
        .tx_ready_o(tx_ready_o), .MISO(MISO), .SCK(SCK), .MOSI(MOSI), .SS(SS),
        .rx_data_o(rx_data_o), .done(done), .busy_o(busy_o)
    );

    spi_master #(.DATA_W(8), .CLK_DIV(2), .CS_GAP(2)) u_dut2 (
        .clk_i(clk), .reset_i(reset_i), .tx_data_i(data2), .tx_valid_i(valid2),
        .tx_ready_o(ready2), .MISO(miso2), .SCK(sck2), .MOSI(mosi2), .SS(ss2),
        .rx_data_o(rx2), .done(done2), .busy_o(busy2)
    );

    // MOSI must stay put whenever SCK is high.
    always @(negedge clk) begin
        if (SCK && (MOSI !== mosi_prev)) mosi_viol++;
        mosi_prev = MOSI;
    end

    // Simple mode-0 slave receiver on the CLK_DIV=2 instance.
    always @(posedge sck2) begin
        if (!ss2) begin
            rcv_sh = {rcv_sh[6:0], mosi2};
            rcv_n++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string name);
        chk({name, " SCK"}, 32'(SCK), 0);
        chk({name, " SS"}, 32'(SS), 1);
        chk({name, " MOSI"}, 32'(MOSI), 0);
        chk({name, " tx_ready_o"}, 32'(tx_ready_o), 1);
        chk({name, " busy_o"}, 32'(busy_o), 0);
        chk({name, " done"}, 32'(done), 0);
        chk({name, " rx_data_o"}, 32'(rx_data_o), 0);
    endtask

    task automatic start(input string name, input logic [7:0] d);
        int n = 0;
        @(negedge clk);
        tx_data_i  = d;
        tx_valid_i = 1'b1;
        while (!tx_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({name, " ready before handshake"}, 32'(tx_ready_o), 1);
        @(posedge clk);
        #1;
    endtask

    // Observe one frame starting just after its handshake edge and compare with the model.
    task automatic run_frame(input string name, input logic [7:0] d, input logic [7:0] miso_w,
                             input bit loop, input logic [7:0] exp_rx, input logic [7:0] next_d,
                             input bit drop);
        int cyc = 0;
        int ss_low = 0;
        int rises = 0;
        logic [7:0] mosi_w = 8'h00;
        logic sck_prev = 1'b0;
        bit seen = 1'b0;
        bit bad_busy = 1'b0;
        logic ss_at_done = 1'b0;
        MISO = loop ? MOSI : miso_w[7];
        while (!seen && cyc < 4 * FRAME) begin
            @(negedge clk);
            cyc++;
            if (cyc == 2) begin
                tx_data_i = 8'($urandom);
                if (drop) tx_valid_i = 1'b0;
            end
            if (cyc == FRAME - 8) tx_data_i = next_d;
            if (!SS) begin
                ss_low++;
                if (!busy_o || tx_ready_o) bad_busy = 1'b1;
            end
            if (SCK && !sck_prev) begin
                mosi_w = {mosi_w[6:0], MOSI};
                rises++;
            end
            sck_prev = SCK;
            if (loop) MISO = MOSI;
            else if (rises < 8) MISO = miso_w[3'(7 - rises)];
            if (done) begin
                seen = 1'b1;
                ss_at_done = SS;
            end
        end
        chk({name, " done seen"}, 32'(seen), 1);
        chk({name, " handshake-to-done cycles"}, cyc, FRAME + 1);
        chk({name, " SS low cycles"}, ss_low, FRAME);
        chk({name, " SCK rises"}, rises, 8);
        chk({name, " MOSI bits"}, 32'(mosi_w), 32'(d));
        chk({name, " rx_data_o"}, 32'(rx_data_o), 32'(exp_rx));
        chk({name, " SS high at done"}, 32'(ss_at_done), 1);
        chk({name, " busy/ready while SS low"}, 32'(bad_busy), 0);
        @(negedge clk);
        chk({name, " done one cycle"}, 32'(done), 0);
        chk({name, " SS high in gap"}, 32'(SS), 1);
        chk({name, " busy in gap"}, 32'(busy_o), 1);
    endtask

    initial begin
        vecs[0] = '{8'hA5, 8'h96, 1'b0, 8'h96};
        vecs[1] = '{8'h3C, 8'h00, 1'b1, 8'h3C};
        vecs[2] = '{8'h00, 8'hFF, 1'b0, 8'hFF};
        vecs[3] = '{8'hFF, 8'h00, 1'b0, 8'h00};
        vecs[4] = '{8'h80, 8'h01, 1'b0, 8'h01};
        vecs[5] = '{8'h01, 8'h80, 1'b1, 8'h01};

        #12;
        chk_reset("reset");
        @(negedge clk);
        reset_i = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset("idle after reset");

        for (int i = 0; i < 6; i++) begin
            start($sformatf("vec%0d", i), vecs[i].data);
            run_frame($sformatf("vec%0d", i), vecs[i].data, vecs[i].miso, vecs[i].loop,
                      vecs[i].exp_rx, 8'($urandom), 1'b1);
        end

        for (int i = 0; i < 16; i++) begin
            logic [7:0] d;
            logic [7:0] m;
            bit lp;
            d  = 8'($urandom);
            m  = 8'($urandom);
            lp = 1'($urandom_range(0, 1));
            start($sformatf("rand%0d", i), d);
            run_frame($sformatf("rand%0d", i), d, m, lp, lp ? d : m, 8'($urandom), 1'b1);
        end

        // Held valid: 0x00 then 0xFF back-to-back, with data churn while busy.
        start("b2b0", 8'h00);
        run_frame("b2b0", 8'h00, 8'h00, 1'b1, 8'h00, 8'hFF, 1'b0);
        @(negedge clk);
        chk("b2b accept cycle SS", 32'(SS), 1);
        chk("b2b accept cycle ready", 32'(tx_ready_o), 1);
        @(posedge clk);
        #1;
        run_frame("b2b1", 8'hFF, 8'h00, 1'b1, 8'hFF, 8'h55, 1'b1);

        // Reset after the third SCK rise of 0xC3.
        begin
            int rises = 0;
            int n = 0;
            logic sck_prev = 1'b0;
            bit saw_done = 1'b0;
            bit saw_ss = 1'b0;
            start("abort", 8'hC3);
            while (rises < 3 && n < 4 * FRAME) begin
                @(negedge clk);
                n++;
                tx_valid_i = 1'b0;
                if (SCK && !sck_prev) rises++;
                sck_prev = SCK;
            end
            chk("abort reached third rise", rises, 3);
            #2;
            reset_i = 1'b1;
            #1;
            chk_reset("abort reset");
            @(negedge clk);
            reset_i = 1'b0;
            for (int i = 0; i < 2 * FRAME; i++) begin
                @(negedge clk);
                if (done) saw_done = 1'b1;
                if (!SS) saw_ss = 1'b1;
            end
            chk("abort no done", 32'(saw_done), 0);
            chk("abort SS stays high", 32'(saw_ss), 0);
        end
        start("after abort", 8'h81);
        run_frame("after abort", 8'h81, 8'h6E, 1'b0, 8'h6E, 8'h00, 1'b1);

        // CLK_DIV=2 instance feeding the slave receiver model.
        begin
            int n0;
            int cyc = 0;
            int ss_low = 0;
            bit seen = 1'b0;
            bit bad_busy = 1'b0;
            n0 = rcv_n;
            @(negedge clk);
            chk("div2 ready", 32'(ready2), 1);
            data2  = 8'h5A;
            valid2 = 1'b1;
            @(posedge clk);
            #1;
            valid2 = 1'b0;
            while (!seen && cyc < 4 * FRAME2) begin
                @(negedge clk);
                cyc++;
                if (!ss2) begin
                    ss_low++;
                    if (!busy2) bad_busy = 1'b1;
                end
                if (done2) seen = 1'b1;
            end
            chk("div2 done seen", 32'(seen), 1);
            chk("div2 SS low cycles", ss_low, FRAME2);
            chk("div2 receiver data", 32'(rcv_sh), 32'h5A);
            chk("div2 receiver bits", rcv_n - n0, 8);
            chk("div2 rx_data_o", 32'(rx2), 0);
            chk("div2 busy while SS low", 32'(bad_busy), 0);
            @(negedge clk);
            chk("div2 done one cycle", 32'(done2), 0);
        end

        chk("MOSI stable while SCK high", mosi_viol, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
